ifu_fetch_ctrl: RTL

Sequencing controller for instruction fetch in the NPC core. It owns the program counter and issues one request at a time to the instruction memory. It presents each returned instruction to decode with a valid/ready handshake. It also applies PC redirects from execute and stops fetching permanently after an `ebreak` is consumed.

---
 rtl/ifu_fetch_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ifu_fetch_ctrl.sv
// rtl/ifu_fetch_ctrl.sv - instruction fetch sequencer: PC ownership, single outstanding imem request, decode handshake
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_VAL = 32'h8000_0000,
  parameter logic [31:0] EBREAK    = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halt,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_data_q;
  logic [31:0] inst_pc_q;
  logic [31:0] fetch_cnt_q;
  logic        kill_q;
  logic        req_valid_q;
  logic        hold_q;
  logic        halt_q;
  logic        addr_en_q;
  logic [31:0] redir_pc;

  assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_VAL;
      inst_data_q <= '0;
      inst_pc_q   <= '0;
      fetch_cnt_q <= '0;
      kill_q      <= 1'b0;
      req_valid_q <= 1'b0;
      hold_q      <= 1'b0;
      halt_q      <= 1'b0;
      addr_en_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q     <= S_REQ;
          req_valid_q <= 1'b1;
          addr_en_q   <= 1'b1;
        end
        S_REQ: begin
          if (redirect_valid) pc_q <= redir_pc;
          if (imem_req_ready) begin
            state_q     <= S_WAIT;
            req_valid_q <= 1'b0;
            // The accepted request targets the old PC; its response must be discarded.
            if (redirect_valid) kill_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (redirect_valid) pc_q <= redir_pc;
          if (imem_resp_valid) begin
            if (kill_q || redirect_valid) begin
              kill_q      <= 1'b0;
              state_q     <= S_REQ;
              req_valid_q <= 1'b1;
            end else begin
              inst_data_q <= imem_resp_data;
              inst_pc_q   <= pc_q;
              state_q     <= S_HOLD;
              hold_q      <= 1'b1;
            end
          end else if (redirect_valid) begin
            kill_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            pc_q        <= redir_pc;
            state_q     <= S_REQ;
            hold_q      <= 1'b0;
            req_valid_q <= 1'b1;
          end else if (inst_ready) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
            pc_q        <= pc_q + 32'd4;
            hold_q      <= 1'b0;
            if (inst_data_q == EBREAK) begin
              state_q <= S_HALT;
              halt_q  <= 1'b1;
            end else begin
              state_q     <= S_REQ;
              req_valid_q <= 1'b1;
            end
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q     <= S_IDLE;
          req_valid_q <= 1'b0;
          hold_q      <= 1'b0;
          addr_en_q   <= 1'b0;
        end
      endcase
    end
  end

  // Address reads as zero only in IDLE so every output is quiet right after reset.
  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = addr_en_q ? pc_q : 32'd0;
  assign inst_valid     = hold_q & ~redirect_valid;
  assign inst_data      = inst_data_q;
  assign inst_pc        = inst_pc_q;
  assign halt           = halt_q;
  assign fetch_cnt      = fetch_cnt_q;

endmodule
